// File: rtl/psum_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | psum_pkg : shared widths, saturation limits and FSM state encoding |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package psum_pkg;

    localparam int LANES  = 16;
    localparam int PSUM_W = 24;
    localparam int CNT_W  = 8;

    localparam logic [23:0] PSUM_MAX = 24'h7FFFFF;
    localparam logic [23:0] PSUM_MIN = 24'h800000;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/psum_sat_add.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | psum_sat_add : one-lane signed saturating adder (combinational)    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module psum_sat_add #(
    parameter int W = psum_pkg::PSUM_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    localparam logic [W-1:0] c_max = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] c_min = {1'b1, {(W-1){1'b0}}};

    logic [W:0] w_full;

    // Sign-extend to W+1 bits so the true sum never wraps.
    assign w_full = {a[W-1], a} + {b[W-1], b};

    always_comb begin
        sum = w_full[W-1:0];
        sat = 1'b0;
        if (w_full[W] != w_full[W-1]) begin
            sat = 1'b1;
            sum = w_full[W] ? c_min : c_max;
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | psum_accumulator : K-tile signed psum accumulation with per-lane   |
// | saturation and a valid/ready output register.        rev 1.0      |
// +--------------------------------------------------------------------+
module psum_accumulator #(
    parameter int LANES  = psum_pkg::LANES,
    parameter int PSUM_W = psum_pkg::PSUM_W,
    parameter int CNT_W  = psum_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_tiles,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*PSUM_W-1:0] in_psum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*PSUM_W-1:0] partial_sum,
    output logic                    busy,
    output logic                    sat_flag
);

    import psum_pkg::*;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [LANES*PSUM_W-1:0]   r_acc;
    logic [LANES*PSUM_W-1:0]   w_sum;
    logic [LANES*PSUM_W-1:0]   r_psum;
    logic [CNT_W-1:0]          r_tile_cnt;
    logic [CNT_W-1:0]          r_last_idx;
    logic                      r_sat;
    logic                      r_out_valid;
    logic                      r_sat_flag;
    logic [LANES-1:0]          w_lane_sat;
    logic                      w_any_clamp;
    logic                      w_final_tile;
    logic                      w_accept;
    logic                      w_final_accept;
    logic                      w_start_ok;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            psum_sat_add #(
                .W (PSUM_W)
            ) u_sat_add (
                .a   (r_acc[i*PSUM_W +: PSUM_W]),
                .b   (in_psum[i*PSUM_W +: PSUM_W]),
                .sum (w_sum[i*PSUM_W +: PSUM_W]),
                .sat (w_lane_sat[i])
            );
        end
    endgenerate

    assign w_any_clamp    = |w_lane_sat;
    assign w_final_tile   = (r_state == ACCUM) && (r_tile_cnt == r_last_idx);
    // The final tile may only land when the output register can take it.
    assign in_ready       = (r_state == ACCUM) &&
                            (!w_final_tile || !r_out_valid || out_ready);
    assign w_accept       = in_valid && in_ready;
    assign w_final_accept = w_accept && w_final_tile;
    assign w_start_ok     = (r_state == IDLE) && start && (num_tiles != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok)     w_state_next = ACCUM;
            ACCUM:   if (w_final_accept) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_tile_cnt <= '0;
            r_last_idx <= '0;
            r_sat      <= 1'b0;
        end else if (w_start_ok) begin
            r_acc      <= '0;
            r_tile_cnt <= '0;
            r_last_idx <= num_tiles - CNT_W'(1);
            r_sat      <= 1'b0;
        end else if (w_accept) begin
            r_sat <= r_sat | w_any_clamp;
            if (w_final_tile) begin
                r_acc <= '0;
            end else begin
                r_acc      <= w_sum;
                r_tile_cnt <= r_tile_cnt + CNT_W'(1);
            end
        end
    end

    // A final accept in the same cycle as a consume reloads rather than clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psum      <= '0;
            r_out_valid <= 1'b0;
            r_sat_flag  <= 1'b0;
        end else if (w_final_accept) begin
            r_psum      <= w_sum;
            r_sat_flag  <= r_sat | w_any_clamp;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign partial_sum = r_psum;
    assign out_valid   = r_out_valid;
    assign sat_flag    = r_sat_flag;
    assign busy        = (r_state == ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_psum_accumulator : directed + random bench with a job-level     |
// | integer reference model.                              rev 1.0      |
// +--------------------------------------------------------------------+
module tb_psum_accumulator;

    localparam int L  = 16;
    localparam int W  = 24;
    localparam int CW = 8;
    localparam int VMAX = 8388607;
    localparam int VMIN = -8388608;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [CW-1:0]   num_tiles;
    logic            in_valid;
    logic            in_ready;
    logic [L*W-1:0]  in_psum;
    logic            out_valid;
    logic            out_ready;
    logic [L*W-1:0]  partial_sum;
    logic            busy;
    logic            sat_flag;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    psum_accumulator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_tiles   (num_tiles),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_psum     (in_psum),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .partial_sum (partial_sum),
        .busy        (busy),
        .sat_flag    (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: job-level bookkeeping with tiles remaining and int lanes.
    bit             m_active;
    int             m_left;
    int             m_acc [L];
    bit             m_sat;
    bit             m_ov;
    logic [L*W-1:0] m_ps;
    bit             m_sf;
    logic           exp_ready;

    assign exp_ready = m_active && (m_left != 1 || !m_ov || out_ready);

    always @(posedge clk or negedge rst_n) begin
        int             t;
        int             tv [L];
        bit             clamp;
        logic [L*W-1:0] nv;
        if (!rst_n) begin
            m_active <= 1'b0;
            m_left   <= 0;
            m_sat    <= 1'b0;
            m_ov     <= 1'b0;
            m_ps     <= '0;
            m_sf     <= 1'b0;
            for (int i = 0; i < L; i++) m_acc[i] <= 0;
        end else begin
            if (m_ov && out_ready) m_ov <= 1'b0;
            if (!m_active) begin
                if (start && num_tiles != 0) begin
                    m_active <= 1'b1;
                    m_left   <= int'(num_tiles);
                    m_sat    <= 1'b0;
                    for (int i = 0; i < L; i++) m_acc[i] <= 0;
                end
            end else if (in_valid && exp_ready) begin
                clamp = 1'b0;
                nv    = '0;
                for (int i = 0; i < L; i++) begin
                    t = m_acc[i] + int'($signed(in_psum[i*W +: W]));
                    if (t > VMAX) begin
                        t = VMAX; clamp = 1'b1;
                    end else if (t < VMIN) begin
                        t = VMIN; clamp = 1'b1;
                    end
                    tv[i] = t;
                    nv[i*W +: W] = t[W-1:0];
                end
                if (m_left == 1) begin
                    m_ps     <= nv;
                    m_sf     <= m_sat | clamp;
                    m_ov     <= 1'b1;
                    m_active <= 1'b0;
                end else begin
                    m_left <= m_left - 1;
                    m_sat  <= m_sat | clamp;
                    for (int i = 0; i < L; i++) m_acc[i] <= tv[i];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare, just before the next rising edge.
    always @(negedge clk) begin
        #4;
        if (chk_en) begin
            chk("m_in_ready",    {{(L*W-1){1'b0}}, in_ready},  {{(L*W-1){1'b0}}, exp_ready});
            chk("m_busy",        {{(L*W-1){1'b0}}, busy},      {{(L*W-1){1'b0}}, m_active});
            chk("m_out_valid",   {{(L*W-1){1'b0}}, out_valid}, {{(L*W-1){1'b0}}, m_ov});
            chk("m_sat_flag",    {{(L*W-1){1'b0}}, sat_flag},  {{(L*W-1){1'b0}}, m_sf});
            chk("m_partial_sum", partial_sum, m_ps);
        end
    end

    function automatic logic [L*W-1:0] rep(input logic [W-1:0] v);
        return {L{v}};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bit1(input string name, input logic act, input logic exp);
        chk(name, {{(L*W-1){1'b0}}, act}, {{(L*W-1){1'b0}}, exp});
    endtask

    task automatic quiet();
        start    = 1'b0;
        in_valid = 1'b0;
        in_psum  = '0;
    endtask

    logic [L*W-1:0] v;

    initial begin
        rst_n = 1'b0; start = 1'b0; num_tiles = '0; in_valid = 1'b0;
        in_psum = '0; out_ready = 1'b1;
        #1;
        bit1("rst_busy", busy, 1'b0);
        bit1("rst_out_valid", out_valid, 1'b0);
        bit1("rst_in_ready", in_ready, 1'b0);
        bit1("rst_sat_flag", sat_flag, 1'b0);
        chk("rst_partial_sum", partial_sum, '0);
        tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // One-tile job
        start = 1'b1; num_tiles = 8'd1; tick();
        start = 1'b0; in_valid = 1'b1; in_psum = rep(24'h000010); tick();
        quiet(); #1;
        bit1("t1_out_valid", out_valid, 1'b1);
        chk("t1_sum", partial_sum, rep(24'h000010));
        bit1("t1_sat", sat_flag, 1'b0);
        tick(); #1;
        bit1("t1_out_valid_drop", out_valid, 1'b0);

        // Three tiles back-to-back, including a negative one
        start = 1'b1; num_tiles = 8'd3; tick();
        start = 1'b0; in_valid = 1'b1; in_psum = rep(24'h000100); tick();
        in_psum = rep(24'h000200); tick();
        in_psum = rep(24'hFFFFB0); tick();
        quiet(); #1;
        bit1("t2_out_valid", out_valid, 1'b1);
        chk("t2_sum", partial_sum, rep(24'h0002B0));
        tick();

        // Saturation both directions
        start = 1'b1; num_tiles = 8'd2; tick();
        start = 1'b0; in_valid = 1'b1;
        v = '0; v[23:0] = 24'h7FFFF0; v[47:24] = 24'h800000; in_psum = v; tick();
        v = '0; v[23:0] = 24'h000020; v[47:24] = 24'hFFFFFF; in_psum = v; tick();
        quiet(); #1;
        v = '0; v[23:0] = 24'h7FFFFF; v[47:24] = 24'h800000;
        chk("t3_sum", partial_sum, v);
        bit1("t3_sat", sat_flag, 1'b1);
        tick();
        start = 1'b1; num_tiles = 8'd1; tick();
        start = 1'b0; in_valid = 1'b1; in_psum = rep(24'h000002); tick();
        quiet(); #1;
        bit1("t3_clean_sat", sat_flag, 1'b0);
        tick();

        // Back-pressure: A held while B accumulates
        out_ready = 1'b0;
        start = 1'b1; num_tiles = 8'd1; tick();
        start = 1'b0; in_valid = 1'b1; in_psum = rep(24'h000005); tick();
        in_valid = 1'b0; start = 1'b1; num_tiles = 8'd2; #1;
        bit1("t4_a_valid", out_valid, 1'b1);
        tick();
        start = 1'b0; in_valid = 1'b1; in_psum = rep(24'h000007); tick();
        in_psum = rep(24'h000009); #1;
        bit1("t4_final_blocked", in_ready, 1'b0);
        tick(); #1;
        bit1("t4_still_blocked", in_ready, 1'b0);
        chk("t4_a_stable", partial_sum, rep(24'h000005));
        tick();
        out_ready = 1'b1; #1;
        bit1("t4_final_open", in_ready, 1'b1);
        tick();
        out_ready = 1'b0; quiet(); #1;
        bit1("t4_b_valid", out_valid, 1'b1);
        chk("t4_b_sum", partial_sum, rep(24'h000010));
        tick();

        // Reset mid-job with a result still pending
        start = 1'b1; num_tiles = 8'd4; tick();
        start = 1'b0; in_valid = 1'b1; in_psum = rep(24'h000001); tick();
        tick();
        quiet(); rst_n = 1'b0; #1;
        bit1("t5_busy", busy, 1'b0);
        bit1("t5_out_valid", out_valid, 1'b0);
        bit1("t5_in_ready", in_ready, 1'b0);
        chk("t5_sum", partial_sum, '0);
        tick();
        rst_n = 1'b1; out_ready = 1'b1; tick();
        start = 1'b1; num_tiles = 8'd1; tick();
        start = 1'b0; in_valid = 1'b1; in_psum = rep(24'h000001); tick();
        quiet(); #1;
        chk("t5_new_job", partial_sum, rep(24'h000001));
        tick();

        // Ignored starts and idle in_valid
        start = 1'b1; num_tiles = 8'd0; tick();
        start = 1'b0; #1;
        bit1("t6_zero_tiles", busy, 1'b0);
        tick();
        start = 1'b1; num_tiles = 8'd2; tick();
        start = 1'b0; in_valid = 1'b1; in_psum = rep(24'h000003); tick();
        start = 1'b1; num_tiles = 8'd5; in_psum = rep(24'h000004); tick();
        quiet(); #1;
        chk("t6_start_in_accum", partial_sum, rep(24'h000007));
        bit1("t6_busy_after", busy, 1'b0);
        tick();
        in_valid = 1'b1; in_psum = rep(24'h0000AA);
        for (int k = 0; k < 3; k++) tick();
        quiet(); #1;
        bit1("t6_idle_valid", busy, 1'b0);
        chk("t6_idle_sum", partial_sum, rep(24'h000007));
        tick();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            rst_n     = ($urandom % 300 == 0) ? 1'b0 : 1'b1;
            start     = ($urandom % 6 == 0);
            num_tiles = CW'($urandom_range(0, 5));
            in_valid  = ($urandom % 4 != 0);
            out_ready = ($urandom % 3 != 0);
            for (int i = 0; i < L; i++) begin
                case ($urandom % 4)
                    0:       in_psum[i*W +: W] = 24'h7FF000 + 24'($urandom % 4096);
                    1:       in_psum[i*W +: W] = 24'h800000 + 24'($urandom % 4096);
                    default: in_psum[i*W +: W] = 24'($urandom);
                endcase
            end
            tick();
        end
        rst_n = 1'b1; quiet(); out_ready = 1'b1;
        tick(); tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
